// File: rtl/des_crypt_unrolled.sv
// Iterative DES core evaluating UNROLL Feistel rounds per clock; one block every 16/UNROLL iterations.
// Optional build macro DES_DECRYPT_EN enables decryption (mode=1) by walking the round keys K16..K1.
module des_crypt_unrolled #(
    parameter int UNROLL = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [63:0]  message,
    input  logic [767:0] round_keys,
    output logic         busy,
    output logic         done,
    output logic [63:0]  result
);

    localparam int ITER = 16 / UNROLL;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int KSH  = 48 * UNROLL;

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
        $error("des_crypt_unrolled: UNROLL must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Permutation tables use DES numbering: entry n names input bit n, bit 1 = MSB.
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int IPI_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25};

    localparam int E_TAB [48] = '{
        32, 1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int P_TAB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1,  15, 23, 26, 5,  18, 31, 10,
        2,  8, 24, 14, 32, 27, 3,  9,  19, 13, 30, 6,  22, 11, 4,  25};

    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] ip_fwd(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TAB[i]];
        return y;
    endfunction

    function automatic logic [63:0] ip_inv(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IPI_TAB[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TAB[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            s[31-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
        return p;
    endfunction

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [63:0]    r_result;
    logic [31:0]    r_l;
    logic [31:0]    r_r;
    logic [767:0]   r_keys;
    logic [31:0]    w_l [UNROLL+1];
    logic [31:0]    w_r [UNROLL+1];
    logic [47:0]    w_key [UNROLL];
    logic           w_accept;
    logic           w_last;

`ifdef DES_DECRYPT_EN
    logic           r_mode;
`else
    logic           w_unused_mode;
    assign w_unused_mode = mode;
`endif

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(ITER - 1));
    assign w_l[0]   = r_l;
    assign w_r[0]   = r_r;

    // Encrypt consumes keys from the top of r_keys; decrypt from the bottom (K16 first).
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
`ifdef DES_DECRYPT_EN
        assign w_key[j] = r_mode ? r_keys[48*j +: 48] : r_keys[767-48*j -: 48];
`else
        assign w_key[j] = r_keys[767-48*j -: 48];
`endif
        assign w_l[j+1] = w_r[j];
        assign w_r[j+1] = w_l[j] ^ feistel(w_r[j], w_key[j]);
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == S_RUN)
                r_cnt <= r_cnt + 1'b1;
            if (w_last)
                r_result <= ip_inv({w_r[UNROLL], w_l[UNROLL]});
        end
    end

    // NOTE: the datapath is deliberately left unreset; nothing observable reads it before an accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            {r_l, r_r} <= ip_fwd(message);
            r_keys     <= round_keys;
`ifdef DES_DECRYPT_EN
            r_mode     <= mode;
`endif
        end else if (r_state == S_RUN) begin
            r_l <= w_l[UNROLL];
            r_r <= w_r[UNROLL];
`ifdef DES_DECRYPT_EN
            r_keys <= r_mode ? (r_keys >> KSH) : (r_keys << KSH);
`else
            r_keys <= r_keys << KSH;
`endif
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_des_crypt_unrolled.sv
// Directed bench for des_crypt_unrolled: five instances (UNROLL 1/2/4/8/16) share one stimulus stream.
// Round keys come from a key-schedule model; expected ciphertexts are published DES vectors.
module tb_des_crypt_unrolled;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] MSG_A = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
    localparam logic [63:0] MSG_B = 64'h8787878787878787;
    localparam logic [63:0] CT_B  = 64'h0000000000000000;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [63:0]  message;
    logic [767:0] round_keys;
    logic [4:0]   busy_v;
    logic [4:0]   done_v;
    logic [63:0]  result_v [5];

    int          n_compared;
    int          n_mismatched;
    int          n;
    int          first_done  [5];
    int          second_done [5];
    int          busy_cnt    [5];
    logic [63:0] res1 [5];
    logic [63:0] res2 [5];
    logic [63:0] mode_exp;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        des_crypt_unrolled #(.UNROLL(1 << g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .mode       (mode),
            .message    (message),
            .round_keys (round_keys),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .result     (result_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [767:0] key_sched(input logic [63:0] key);
        logic [55:0]  cd;
        logic [27:0]  c;
        logic [27:0]  d;
        logic [47:0]  k;
        logic [767:0] rk;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
            rk[767-48*r -: 48] = k;
        end
        return rk;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        n = -1;
        for (int g = 0; g < 5; g++) begin
            first_done[g]  = -1;
            second_done[g] = -1;
            busy_cnt[g]    = 0;
            res1[g]        = '0;
            res2[g]        = '0;
        end
    endtask

    // Advance to the next falling edge and record busy/done/result of every instance.
    task automatic step();
        @(negedge clk);
        n++;
        for (int g = 0; g < 5; g++) begin
            if (busy_v[g]) busy_cnt[g]++;
            if (done_v[g]) begin
                if (first_done[g] < 0) begin
                    first_done[g] = n;
                    res1[g]       = result_v[g];
                end else if (second_done[g] < 0) begin
                    second_done[g] = n;
                    res2[g]        = result_v[g];
                end
            end
        end
    endtask

    // One-cycle start pulse; afterwards n=0 is the cycle right after the accept edge.
    task automatic launch(input logic [63:0] msg, input logic [63:0] key, input logic md);
        start      = 1'b1;
        message    = msg;
        round_keys = key_sched(key);
        mode       = md;
        clear_obs();
        step();
        start = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        mode         = 1'b0;
        message      = '0;
        round_keys   = '0;
        clear_obs();
        repeat (3) @(negedge clk);

        for (int g = 0; g < 5; g++) begin
            check($sformatf("reset_busy_u%0d", 1 << g), 64'(busy_v[g]), 64'd0);
            check($sformatf("reset_done_u%0d", 1 << g), 64'(done_v[g]), 64'd0);
            check($sformatf("reset_result_u%0d", 1 << g), result_v[g], 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        launch(MSG_A, KEY_A, 1'b0);
        repeat (20) step();
        for (int g = 0; g < 5; g++) begin
            check($sformatf("enc_latency_u%0d", 1 << g), 64'(first_done[g]), 64'(16 >> g));
            check($sformatf("enc_result_u%0d", 1 << g), res1[g], CT_A);
            check($sformatf("enc_busy_cycles_u%0d", 1 << g), 64'(busy_cnt[g]), 64'(16 >> g));
            check($sformatf("enc_single_done_u%0d", 1 << g), 64'(second_done[g]), 64'(-1));
        end

`ifdef DES_DECRYPT_EN
        mode_exp = MSG_A;
        launch(CT_A, KEY_A, 1'b1);
`else
        mode_exp = CT_A;
        launch(MSG_A, KEY_A, 1'b1);
`endif
        repeat (20) step();
        for (int g = 0; g < 5; g++) begin
            check($sformatf("mode1_latency_u%0d", 1 << g), 64'(first_done[g]), 64'(16 >> g));
            check($sformatf("mode1_result_u%0d", 1 << g), res1[g], mode_exp);
        end
        check("result_held_u4", result_v[2], mode_exp);

        launch(MSG_A, KEY_A, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        for (int g = 0; g < 5; g++) begin
            check($sformatf("midrun_rst_result_u%0d", 1 << g), result_v[g], 64'd0);
        end
        check("midrun_rst_busy_u4", 64'(busy_v[2]), 64'd0);
        check("midrun_rst_done_u4", 64'(done_v[2]), 64'd0);
        rst_n = 1'b1;
        clear_obs();
        repeat (12) step();
        check("no_done_after_rst_u4", 64'(first_done[2]), 64'(-1));
        check("idle_result_after_rst_u4", result_v[2], 64'd0);
        launch(MSG_A, KEY_A, 1'b0);
        repeat (20) step();
        check("fresh_latency_u4", 64'(first_done[2]), 64'd4);
        check("fresh_result_u4", res1[2], CT_A);

        launch(MSG_B, KEY_B, 1'b0);
        repeat (20) step();
        for (int g = 0; g < 5; g++) begin
            check($sformatf("vecb_latency_u%0d", 1 << g), 64'(first_done[g]), 64'(16 >> g));
            check($sformatf("vecb_result_u%0d", 1 << g), res1[g], CT_B);
        end

        launch(MSG_A, KEY_A, 1'b0);
        step();
        start      = 1'b1;
        message    = 64'hDEADBEEFCAFEF00D;
        round_keys = ~round_keys;
        mode       = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start      = 1'b1;
        message    = MSG_B;
        round_keys = key_sched(KEY_B);
        mode       = 1'b0;
        step();
        start = 1'b0;
        repeat (15) step();
        check("b2b_first_latency_u4", 64'(first_done[2]), 64'd4);
        check("b2b_first_result_u4", res1[2], CT_A);
        check("b2b_second_done_u4", 64'(second_done[2]), 64'd9);
        check("b2b_second_result_u4", res2[2], CT_B);
        check("b2b_busy_cycles_u4", 64'(busy_cnt[2]), 64'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
